// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Arbitrates the single register-file write port between two writeback
// sources. Requester A is the main pipeline: it has no ready and always wins
// unless told to stall. Requester B is a multi-cycle unit: its write is taken
// into a one-entry buffer on a valid/ready handshake. The buffer drains when
// the port is free. A scoreboard tracks registers with an outstanding B
// operation, so decode can detect hazards.
//
// Optional feature (macro RF_WB_STARVE_GUARD_EN):
//   When defined, a 4-bit starve counter counts the cycles a buffered B entry
//   loses to A. When it reaches STARVE_MAX, the FORCE state stalls A for one
//   cycle and drains B. When undefined, a buffered B entry waits for a cycle
//   with a_valid=0, and a_stall is tied low.
//
// Ports:
//   clk, reset             clock; asynchronous active-low reset
//   a_valid/a_addr/a_data  requester A write request
//   a_stall                A must hold its request while high (combinational)
//   b_valid/b_ready        requester B handshake
//   b_addr/b_data          requester B write request
//   issue_valid/issue_dst  B operation issue, marks issue_dst pending
//   rs_addr/rt_addr        decode source probes
//   rs_busy/rt_busy        probed register has a pending B write
//   rf_wr/rf_addr/rf_data  registered register-file write port
//   sb_err                 sticky: issue to an already-pending register
module rf_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dst,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_busy,
  output logic        rt_busy,
  output logic        rf_wr,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        sb_err
);

`ifdef RF_WB_STARVE_GUARD_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_FORCE} state_t;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_reg;
`else
  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD} state_t;
`endif

  state_t      state_reg;
  logic [4:0]  hold_addr_reg;
  logic [31:0] hold_data_reg;
  logic        rf_from_b_reg;   // the write now on rf_* came from B

  logic        sel_a;
  logic        sel_b;
  logic        commit;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;

  logic [31:1] pending_vec;
  logic [31:0] pending_full;    // bit 0 is always clear, so any 5-bit index is safe

  // Source selection for this cycle. A wins unless B is being forced.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    case (state_reg)
      ST_EMPTY: sel_a = a_valid;
      ST_HOLD: begin
        sel_a = a_valid;
        sel_b = ~a_valid;
      end
`ifdef RF_WB_STARVE_GUARD_EN
      ST_FORCE: sel_b = 1'b1;
`endif
      default: begin
        sel_a = 1'b0;
        sel_b = 1'b0;
      end
    endcase
  end

  assign commit      = sel_a | sel_b;
  assign commit_addr = sel_a ? a_addr : hold_addr_reg;
  assign commit_data = sel_a ? a_data : hold_data_reg;

  // b_ready is low while reset is held, even though the state already reads EMPTY.
  // In HOLD it stays low on the drain cycle too, so the buffer never fills and drains at once.
  assign b_ready = reset & (state_reg == ST_EMPTY);

`ifdef RF_WB_STARVE_GUARD_EN
  assign a_stall = (state_reg == ST_FORCE);
`else
  assign a_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_EMPTY;
      hold_addr_reg <= 5'd0;
      hold_data_reg <= 32'd0;
      rf_wr         <= 1'b0;
      rf_addr       <= 5'd0;
      rf_data       <= 32'd0;
      rf_from_b_reg <= 1'b0;
`ifdef RF_WB_STARVE_GUARD_EN
      starve_reg    <= 4'd0;
`endif
    end else begin
      // A commit to register 0 uses up the slot but writes nothing.
      // rf_addr/rf_data keep their last real write.
      rf_wr         <= commit && (commit_addr != 5'd0);
      rf_from_b_reg <= sel_b;
      if (commit && (commit_addr != 5'd0)) begin
        rf_addr <= commit_addr;
        rf_data <= commit_data;
      end

      case (state_reg)
        ST_EMPTY: begin
          if (b_valid) begin
            hold_addr_reg <= b_addr;
            hold_data_reg <= b_data;
            state_reg     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (a_valid) begin
`ifdef RF_WB_STARVE_GUARD_EN
            if (starve_reg + 4'd1 == STARVE_LIM) begin
              state_reg  <= ST_FORCE;
              starve_reg <= 4'd0;
            end else begin
              starve_reg <= starve_reg + 4'd1;
            end
`endif
          end else begin
            state_reg <= ST_EMPTY;
`ifdef RF_WB_STARVE_GUARD_EN
            starve_reg <= 4'd0;
`endif
          end
        end
`ifdef RF_WB_STARVE_GUARD_EN
        ST_FORCE: state_reg <= ST_EMPTY;
`endif
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  // Scoreboard: one flop per register 1..31.
  // The clear is taken from the registered B write on rf_*.
  // A set in the same cycle wins over the clear.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_sb
      logic bit_reg;
      logic set_bit;
      logic clr_bit;
      assign set_bit = issue_valid && (issue_dst == 5'(gi));
      assign clr_bit = rf_wr && rf_from_b_reg && (rf_addr == 5'(gi));
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          bit_reg <= 1'b0;
        end else if (set_bit) begin
          bit_reg <= 1'b1;
        end else if (clr_bit) begin
          bit_reg <= 1'b0;
        end
      end
      assign pending_vec[gi] = bit_reg;
    end
  endgenerate

  assign pending_full = {pending_vec, 1'b0};
  assign rs_busy      = pending_full[rs_addr];
  assign rt_busy      = pending_full[rt_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_err <= 1'b0;
    end else if (issue_valid && pending_full[issue_dst]) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter. It has four parts:
// - a directed table of per-cycle vectors,
// - hand sequences for reset during HOLD and for B starvation,
// - a randomized run checked against a transaction-level model.
module tb_rf_wb_arbiter;
  localparam int SM = 4;
`ifdef RF_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_addr, b_addr, issue_dst, rs_addr, rt_addr;
  logic [31:0] a_data, b_data;
  logic        a_stall, b_ready, rs_busy, rt_busy, rf_wr, sb_err;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_checks = 0;
  int n_pass   = 0;

  rf_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_dst(issue_dst),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    issue_valid = 0; issue_dst = 0; rs_addr = 0; rt_addr = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic iv; logic [4:0] id; logic [4:0] rs; logic [4:0] rt;
    logic e_wr; logic [4:0] e_addr; logic [31:0] e_data;
    logic e_br; logic e_rs; logic e_rt; logic e_err;
  } vec_t;

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic iv, logic [4:0] id, logic [4:0] rs, logic [4:0] rt,
                              logic e_wr, logic [4:0] e_addr, logic [31:0] e_data,
                              logic e_br, logic e_rs, logic e_rt, logic e_err);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.iv = iv; v.id = id; v.rs = rs; v.rt = rt;
    v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
    v.e_br = e_br; v.e_rs = e_rs; v.e_rt = e_rt; v.e_err = e_err;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Tracks the buffered B write, how often it has lost the port to A,
  // the pending-register set, and the write the port will show next cycle.
  bit        m_rf_wr, m_rf_from_b;
  bit [4:0]  m_rf_addr;
  bit [31:0] m_rf_data;
  bit        m_have, m_forcing;
  bit [4:0]  m_eaddr;
  bit [31:0] m_edata;
  int        m_lost;
  bit        m_pend[32];
  bit        m_err;

  task automatic model_reset();
    m_rf_wr = 0; m_rf_from_b = 0; m_rf_addr = 0; m_rf_data = 0;
    m_have = 0; m_forcing = 0; m_eaddr = 0; m_edata = 0; m_lost = 0; m_err = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  task automatic model_check();
    chk_bit("rnd_rf_wr", rf_wr, m_rf_wr);
    if (m_rf_wr) begin
      chk_val("rnd_rf_addr", {27'd0, rf_addr}, {27'd0, m_rf_addr});
      chk_val("rnd_rf_data", rf_data, m_rf_data);
    end
    chk_bit("rnd_b_ready", b_ready, !m_have);
    chk_bit("rnd_a_stall", a_stall, GUARD && m_forcing);
    chk_bit("rnd_rs_busy", rs_busy, m_pend[rs_addr]);
    chk_bit("rnd_rt_busy", rt_busy, m_pend[rt_addr]);
    chk_bit("rnd_sb_err", sb_err, m_err);
  endtask

  task automatic model_step();
    bit take_a, take_b;
    take_a = a_valid && !m_forcing;
    take_b = m_have && (m_forcing || !a_valid);
    // scoreboard: error test against current set, then clear, then set (set wins)
    if (issue_valid && issue_dst != 0 && m_pend[issue_dst]) m_err = 1;
    if (m_rf_wr && m_rf_from_b) m_pend[m_rf_addr] = 0;
    if (issue_valid && issue_dst != 0) m_pend[issue_dst] = 1;
    // write port
    m_rf_wr = 0; m_rf_from_b = 0;
    if (take_a) begin
      if (a_addr != 0) begin m_rf_wr = 1; m_rf_addr = a_addr; m_rf_data = a_data; end
    end else if (take_b) begin
      if (m_eaddr != 0) begin
        m_rf_wr = 1; m_rf_from_b = 1; m_rf_addr = m_eaddr; m_rf_data = m_edata;
      end
    end
    // B buffer
    if (take_b) begin
      m_have = 0; m_lost = 0; m_forcing = 0;
    end else if (m_have) begin
      if (GUARD) begin
        m_lost++;
        if (m_lost >= SM) begin m_forcing = 1; m_lost = 0; end
      end
    end else if (b_valid) begin
      m_have = 1; m_eaddr = b_addr; m_edata = b_data;
    end
  endtask

  // ---------------- main ----------------
  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1,5,32'h1234, 0,0,0,         0,0, 0,0, 0,0,0,            1,0,0,0);
    tbl[1]  = mk(0,0,0,        0,0,0,         0,0, 0,0, 1,5,32'h1234,     1,0,0,0);
    tbl[2]  = mk(0,0,0,        1,7,32'hBEEF,  1,0, 0,0, 0,0,0,            1,0,0,0);
    tbl[3]  = mk(0,0,0,        0,0,0,         0,0, 0,0, 0,0,0,            0,0,0,0);
    tbl[4]  = mk(0,0,0,        0,0,0,         0,0, 0,0, 1,7,32'hBEEF,     1,0,0,0);
    tbl[5]  = mk(0,0,0,        0,0,0,         1,9, 9,0, 0,0,0,            1,0,0,0);
    tbl[6]  = mk(0,0,0,        1,9,32'hCAFE,  0,0, 9,9, 0,0,0,            1,1,1,0);
    tbl[7]  = mk(0,0,0,        0,0,0,         0,0, 9,0, 0,0,0,            0,1,0,0);
    tbl[8]  = mk(0,0,0,        0,0,0,         0,0, 9,0, 1,9,32'hCAFE,     1,1,0,0);
    tbl[9]  = mk(0,0,0,        1,9,32'h1111,  1,9, 9,0, 0,0,0,            1,0,0,0);
    tbl[10] = mk(0,0,0,        0,0,0,         0,0, 9,0, 0,0,0,            0,1,0,0);
    tbl[11] = mk(0,0,0,        0,0,0,         1,9, 9,0, 1,9,32'h1111,     1,1,0,0);
    tbl[12] = mk(0,0,0,        0,0,0,         0,0, 9,9, 0,0,0,            1,1,1,1);
    tbl[13] = mk(0,0,0,        0,0,0,         1,0, 0,9, 0,0,0,            1,0,1,1);
    tbl[14] = mk(1,0,32'hDEAD, 0,0,0,         0,0, 0,0, 0,0,0,            1,0,0,1);
    tbl[15] = mk(1,3,32'h33,   0,0,0,         0,0, 0,0, 0,0,0,            1,0,0,1);
    tbl[16] = mk(0,0,0,        1,4,32'h44,    0,0, 0,0, 1,3,32'h33,       1,0,0,1);
    tbl[17] = mk(1,6,32'h66,   0,0,0,         0,0, 0,0, 0,0,0,            0,0,0,1);
    tbl[18] = mk(0,0,0,        0,0,0,         0,0, 0,0, 1,6,32'h66,       0,0,0,1);
    tbl[19] = mk(0,0,0,        0,0,0,         0,0, 0,0, 1,4,32'h44,       1,0,0,1);

    // ---- reset state ----
    idle_inputs();
    reset = 0;
    tick(); tick();
    chk_bit("rst_rf_wr", rf_wr, 1'b0);
    chk_val("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    chk_val("rst_rf_data", rf_data, 32'd0);
    chk_bit("rst_b_ready", b_ready, 1'b0);
    chk_bit("rst_sb_err", sb_err, 1'b0);
    chk_bit("rst_a_stall", a_stall, 1'b0);
    @(negedge clk);
    reset = 1;
    tick();

    // ---- directed table ----
    for (int i = 0; i < 20; i++) begin
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      issue_valid = tbl[i].iv; issue_dst = tbl[i].id;
      rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
      @(negedge clk);
      chk_bit($sformatf("tbl%0d_rf_wr", i), rf_wr, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        chk_val($sformatf("tbl%0d_rf_addr", i), {27'd0, rf_addr}, {27'd0, tbl[i].e_addr});
        chk_val($sformatf("tbl%0d_rf_data", i), rf_data, tbl[i].e_data);
      end
      chk_bit($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].e_br);
      chk_bit($sformatf("tbl%0d_a_stall", i), a_stall, 1'b0);
      chk_bit($sformatf("tbl%0d_rs_busy", i), rs_busy, tbl[i].e_rs);
      chk_bit($sformatf("tbl%0d_rt_busy", i), rt_busy, tbl[i].e_rt);
      chk_bit($sformatf("tbl%0d_sb_err", i), sb_err, tbl[i].e_err);
      tick();
    end

    // ---- reset while HOLD has register 3 buffered ----
    idle_inputs();
    issue_valid = 1; issue_dst = 3;
    tick();
    idle_inputs();
    b_valid = 1; b_addr = 3; b_data = 32'h3333;
    a_valid = 1; a_addr = 8; a_data = 32'h88; rs_addr = 3;
    @(negedge clk);
    chk_bit("rh_rs_busy_set", rs_busy, 1'b1);
    chk_bit("rh_b_ready_empty", b_ready, 1'b1);
    tick();
    b_valid = 0;
    @(negedge clk);
    chk_bit("rh_b_ready_hold", b_ready, 1'b0);
    chk_bit("rh_rf_wr_a", rf_wr, 1'b1);
    #2 reset = 0;
    #1;
    chk_bit("rh_rf_wr_async", rf_wr, 1'b0);
    chk_bit("rh_b_ready_async", b_ready, 1'b0);
    chk_bit("rh_rs_busy_clr", rs_busy, 1'b0);
    chk_bit("rh_sb_err_clr", sb_err, 1'b0);
    a_valid = 0;
    @(negedge clk);
    reset = 1;
    #1;
    chk_bit("rh_b_ready_after", b_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk_bit($sformatf("rh_no_write%0d", k), rf_wr, 1'b0);
    end
    tick();

    // ---- starvation: B buffered, A held valid ----
    for (int k = 0; k < 14; k++) begin
      int kind;  // 0 none, 1 A write, 2 B write expected on rf_*
      bit e_stall, e_br;
      idle_inputs();
      if (k == 0) begin b_valid = 1; b_addr = 12; b_data = 32'hABC; end
      if (k >= 1 && k <= 10) begin a_valid = 1; a_addr = 13; a_data = 32'h1313; end
`ifdef RF_WB_STARVE_GUARD_EN
      kind    = ((k >= 2 && k <= 5) || (k >= 7 && k <= 11)) ? 1 : (k == 6) ? 2 : 0;
      e_stall = (k == SM + 1);
      e_br    = (k == 0) || (k >= SM + 2);
`else
      kind    = (k >= 2 && k <= 11) ? 1 : (k == 12) ? 2 : 0;
      e_stall = 1'b0;
      e_br    = (k == 0) || (k >= 12);
`endif
      @(negedge clk);
      chk_bit($sformatf("stv%0d_rf_wr", k), rf_wr, kind != 0);
      if (kind != 0) begin
        chk_val($sformatf("stv%0d_rf_addr", k), {27'd0, rf_addr}, (kind == 1) ? 32'd13 : 32'd12);
        chk_val($sformatf("stv%0d_rf_data", k), rf_data, (kind == 1) ? 32'h1313 : 32'hABC);
      end
      chk_bit($sformatf("stv%0d_a_stall", k), a_stall, e_stall);
      chk_bit($sformatf("stv%0d_b_ready", k), b_ready, e_br);
      tick();
    end

    // ---- randomized run against the model ----
    idle_inputs();
    reset = 0;
    tick(); tick();
    @(negedge clk);
    reset = 1;
    model_reset();
    tick();
    for (int c = 0; c < 1500; c++) begin
      if (!a_stall) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_addr  = 5'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      b_valid     = ($urandom_range(0, 99) < 50);
      b_addr      = 5'($urandom_range(0, 7));
      b_data      = $urandom;
      issue_valid = ($urandom_range(0, 99) < 15);
      issue_dst   = 5'($urandom_range(0, 15));
      rs_addr     = 5'($urandom_range(0, 15));
      rt_addr     = 5'($urandom_range(0, 15));
      @(negedge clk);
      model_check();
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
